// File: rtl/button_debounce_if.sv
// Pin and pulse bundle for button_debounce: raw pins in, conditioned levels and pulses out.
// slave is the debouncer side, master is the pin-driving / pulse-consuming side.
interface button_debounce_if #(
    parameter int unsigned NUM_BTN = 4
) ();
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop sync, shared tick prescaler, per-channel debounce FSM.
// Auto-repeat pulses are built only when BUTTON_DEBOUNCE_REPEAT_EN is defined.
module button_debounce #(
    parameter int unsigned NUM_BTN            = 4,
    parameter int unsigned TICK_DIV           = 12000,
    parameter int unsigned DEBOUNCE_TICKS     = 20,
    parameter bit          ACTIVE_LOW         = 1'b1,
    parameter int unsigned REPEAT_DELAY_TICKS = 500,
    parameter int unsigned REPEAT_RATE_TICKS  = 100
) (
    input logic              clk,
    input logic              rst_n,
    button_debounce_if.slave bus
);

    typedef enum logic [1:0] {StReleased, StPressChk, StPressed, StReleaseChk} state_e;

    localparam int unsigned PreW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);
    localparam logic [NUM_BTN-1:0] PinIdle = {NUM_BTN{ACTIVE_LOW}};

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int unsigned HoldW = $clog2(REPEAT_DELAY_TICKS + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(REPEAT_DELAY_TICKS - 1);
    // Reloading here makes the next HoldLast hit land REPEAT_RATE_TICKS ticks later.
    localparam logic [HoldW-1:0] HoldReload = HoldW'(REPEAT_DELAY_TICKS - REPEAT_RATE_TICKS);
`endif

    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_RATE_TICKS < 1 ||
        REPEAT_RATE_TICKS > REPEAT_DELAY_TICKS) begin : g_param_check
        $error("button_debounce: illegal parameter combination");
    end

    logic [NUM_BTN-1:0] sync1_q, sync2_q, s;
    logic [PreW-1:0]    pre_q;
    logic               tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= PinIdle;
            sync2_q <= PinIdle;
        end else begin
            sync1_q <= bus.btn_in;
            sync2_q <= sync1_q;
        end
    end

    // s = 1 means pressed regardless of pin polarity.
    assign s = sync2_q ^ PinIdle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PreW'(1);
        end
    end

    assign tick = (pre_q == PreLast);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_e          state_q;
        logic [CntW-1:0] cnt_q;
        logic            level_q, press_q, release_q;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        logic [HoldW-1:0] hold_q;
        logic             repeat_q;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StReleased;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
                hold_q    <= '0;
                repeat_q  <= 1'b0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
                repeat_q  <= 1'b0;
                if (state_q != StPressed) hold_q <= '0;
`endif
                // An input reversal is checked before tick, so it always wins.
                unique case (state_q)
                    StReleased: begin
                        if (s[i]) begin
                            state_q <= StPressChk;
                            cnt_q   <= '0;
                        end
                    end
                    StPressChk: begin
                        if (!s[i]) begin
                            state_q <= StReleased;
                        end else if (tick) begin
                            cnt_q <= cnt_q + CntW'(1);
                            if (cnt_q == CntLast) begin
                                state_q <= StPressed;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                            end
                        end
                    end
                    StPressed: begin
                        if (!s[i]) begin
                            state_q <= StReleaseChk;
                            cnt_q   <= '0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
                            hold_q  <= '0;
                        end else if (tick) begin
                            if (hold_q == HoldLast) begin
                                repeat_q <= 1'b1;
                                hold_q   <= HoldReload;
                            end else begin
                                hold_q <= hold_q + HoldW'(1);
                            end
`endif
                        end
                    end
                    StReleaseChk: begin
                        if (s[i]) begin
                            state_q <= StPressed;
                        end else if (tick) begin
                            cnt_q <= cnt_q + CntW'(1);
                            if (cnt_q == CntLast) begin
                                state_q   <= StReleased;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StReleased;
                endcase
            end
        end

        assign bus.btn_level[i]   = level_q;
        assign bus.btn_press[i]   = press_q;
        assign bus.btn_release[i] = release_q;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        assign bus.btn_repeat[i]  = repeat_q;
`endif
    end

`ifndef BUTTON_DEBOUNCE_REPEAT_EN
    assign bus.btn_repeat = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: tick-arithmetic reference model checked every cycle,
// plus directed latency/pulse checks. Repeat checks follow BUTTON_DEBOUNCE_REPEAT_EN.
module tb_button_debounce;
    localparam int NB = 4;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int RD = 5;
    localparam int RR = 2;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam bit RepOn = 1'b1;
`else
    localparam bit RepOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    button_debounce_if #(.NUM_BTN(NB)) bus ();

    button_debounce #(
        .NUM_BTN(NB),
        .TICK_DIV(TD),
        .DEBOUNCE_TICKS(DT),
        .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY_TICKS(RD),
        .REPEAT_RATE_TICKS(RR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. k counts active edges since reset; edge k carries a tick iff k%TD==0,
    // so ticks in (a,b] = b/TD - a/TD. A change is accepted once the normalized input has
    // disagreed with the accepted level on every edge of a run spanning DT ticks.
    int k;
    logic [NB-1:0] p1, p2, m_level, m_press, m_release, m_repeat;
    int run_start [NB];
    int hold_start [NB];
    int h;

    initial begin : model
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k = 0;
                p1 = '1;
                p2 = '1;
                m_level = '0;
                m_press = '0;
                m_release = '0;
                m_repeat = '0;
                for (int i = 0; i < NB; i++) begin
                    run_start[i] = -1;
                    hold_start[i] = 0;
                end
            end else begin
                k++;
                m_press = '0;
                m_release = '0;
                m_repeat = '0;
                for (int i = 0; i < NB; i++) begin
                    if ((~p2[i]) == m_level[i]) begin
                        if (run_start[i] >= 0 && m_level[i]) begin
                            hold_start[i] = k;
                        end else if (RepOn && m_level[i] && (k % TD == 0)) begin
                            h = k / TD - hold_start[i] / TD;
                            if (h >= RD && (h - RD) % RR == 0) m_repeat[i] = 1'b1;
                        end
                        run_start[i] = -1;
                    end else if (run_start[i] < 0) begin
                        run_start[i] = k;
                    end else if (k / TD - run_start[i] / TD == DT) begin
                        m_level[i] = ~m_level[i];
                        m_press[i] = m_level[i];
                        m_release[i] = ~m_level[i];
                        run_start[i] = -1;
                        hold_start[i] = k;
                    end
                end
                p2 = p1;
                p1 = bus.btn_in;
            end
        end
    end

    int press_cnt [NB];
    int release_cnt [NB];
    int repeat_cnt [NB];

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n && !done) begin
                check("level", 32'(bus.btn_level), 32'(m_level));
                check("press", 32'(bus.btn_press), 32'(m_press));
                check("release", 32'(bus.btn_release), 32'(m_release));
                check("repeat", 32'(bus.btn_repeat), 32'(m_repeat));
                for (int i = 0; i < NB; i++) begin
                    press_cnt[i] += int'(bus.btn_press[i]);
                    release_cnt[i] += int'(bus.btn_release[i]);
                    repeat_cnt[i] += int'(bus.btn_repeat[i]);
                end
            end
        end
    end

    task automatic clr_cnt();
        for (int i = 0; i < NB; i++) begin
            press_cnt[i] = 0;
            release_cnt[i] = 0;
            repeat_cnt[i] = 0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // which: 0 = btn_level, 1 = btn_repeat. Returns edges waited, budget+1 on timeout.
    task automatic wait_sig(input int which, input int ch, input logic val, input int budget,
                            output int lat);
        logic seen;
        lat = budget + 1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            seen = (which == 0) ? bus.btn_level[ch] : bus.btn_repeat[ch];
            if (seen == val) begin
                lat = n;
                break;
            end
        end
        #1;
    endtask

    initial begin : stim
        int lat;
        clr_cnt();
        bus.btn_in = '1;
        rst_n = 1'b0;
        step(3);
        check("rst_level", 32'(bus.btn_level), 0);
        check("rst_press", 32'(bus.btn_press), 0);
        check("rst_release", 32'(bus.btn_release), 0);
        check("rst_repeat", 32'(bus.btn_repeat), 0);
        rst_n = 1'b1;
        step(40);
        check("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        check("idle_release", release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3], 0);

        // Clean press on channel 0.
        clr_cnt();
        bus.btn_in[0] = 1'b0;
        wait_sig(0, 0, 1'b1, 30, lat);
        check($sformatf("press_latency(%0d)_in_11_15", lat), 32'(lat >= 11 && lat <= 15), 1);
        check("press_edge", 32'(bus.btn_press), 32'h1);
        step(1);
        check("press_width", 32'(bus.btn_press), 0);
        check("press_count", press_cnt[0], 1);
        check("others_idle", 32'(bus.btn_level[3:1]), 0);

        // Bounce on channel 1: 3-cycle pulses never span DT ticks.
        clr_cnt();
        for (int t = 0; t < 10; t++) begin
            bus.btn_in[1] = ~bus.btn_in[1];
            step(3);
        end
        bus.btn_in[1] = 1'b1;
        step(20);
        check("bounce_level", 32'(bus.btn_level[1]), 0);
        check("bounce_press", press_cnt[1], 0);
        check("bounce_release", release_cnt[1], 0);

        // Release channel 0 with a 2-cycle low glitch inside the release check.
        clr_cnt();
        bus.btn_in[0] = 1'b1;
        step(5);
        bus.btn_in[0] = 1'b0;
        step(2);
        bus.btn_in[0] = 1'b1;
        step(10);
        check("glitch_restart_level", 32'(bus.btn_level[0]), 1);
        wait_sig(0, 0, 1'b0, 20, lat);
        check($sformatf("release_latency(%0d)_in_11_15", lat + 10),
              32'(lat + 10 >= 11 && lat + 10 <= 15), 1);
        check("release_edge", 32'(bus.btn_release), 32'h1);
        step(1);
        check("release_width", 32'(bus.btn_release), 0);
        check("release_count", release_cnt[0], 1);
        check("glitch_no_press", press_cnt[0], 0);

        // Simultaneous press on channels 2 and 3.
        clr_cnt();
        bus.btn_in[3:2] = 2'b00;
        wait_sig(0, 2, 1'b1, 30, lat);
        check("simul_press", 32'(bus.btn_press), 32'hC);
        check($sformatf("simul_latency(%0d)_in_11_15", lat), 32'(lat >= 11 && lat <= 15), 1);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        wait_sig(1, 2, 1'b1, 30, lat);
        check("repeat_first_delay", lat, 20);
        check("repeat_pair", 32'(bus.btn_repeat), 32'hC);
        wait_sig(1, 2, 1'b1, 30, lat);
        check("repeat_rate", lat, 8);
`else
        step(30);
        check("repeat_off", repeat_cnt[2] + repeat_cnt[3], 0);
`endif

        // Async reset in the middle of channel 0's press check.
        clr_cnt();
        bus.btn_in[0] = 1'b0;
        step(6);
        rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(bus.btn_level), 0);
        check("midrst_press", 32'(bus.btn_press), 0);
        step(2);
        rst_n = 1'b1;
        wait_sig(0, 0, 1'b1, 30, lat);
        check($sformatf("repress_latency(%0d)_in_11_15", lat), 32'(lat >= 11 && lat <= 15), 1);
        check("repress_edge", 32'(bus.btn_press), 32'hD);
        step(2);
        check("repress_count", press_cnt[0], 1);

        done = 1'b1;
        step(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
